// File: rtl/input_register_pkg.sv
// Shared definitions for the operator-entry register: FSM encodings and default sizing.
package input_register_pkg;

  typedef enum logic {
    STATE_EDIT    = 1'b0,
    STATE_PENDING = 1'b1
  } state_t;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;
  localparam int DEFAULT_DIGITS          = 6;
  localparam int DEFAULT_BUS_WIDTH       = 32;
  localparam int CURSOR_WIDTH            = 3;

endpackage

// File: rtl/input_register_button.sv
// button_debouncer: two-flop synchroniser, stability counter and one-cycle press pulse
// for a single active-low board button.
module button_debouncer
  import input_register_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_n,
  input  logic btn_n,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;

  // Counter only runs while the synchronised level disagrees with the accepted one,
  // so any bounce back to the accepted level restarts the stability window.
  always_comb begin
    sync1_d = btn_n;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = '0;
    press_d = 1'b0;
    if (!clear_n) begin
      sync1_d = 1'b1;
      sync2_d = 1'b1;
      level_d = 1'b1;
    end else if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        press_d = ~sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/input_register.sv
// Operator-entry register: three buttons edit a hex value, COMMIT latches it as pending
// data for the CPU, which reads it off the shared tri-state bus and acknowledges.
module input_register
  import input_register_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int DIGITS          = DEFAULT_DIGITS,
  parameter int BUS_WIDTH       = DEFAULT_BUS_WIDTH
) (
  input  logic                    i_SYS_CLOCK,
  input  logic                    i_RESET,
  input  logic                    i_CLEAR_n,
  input  logic                    i_BTN_DIGIT,
  input  logic                    i_BTN_INC,
  input  logic                    i_BTN_COMMIT,
  input  logic                    i_OUTPUT_n,
  input  logic                    i_ACK,
  inout  wire  [BUS_WIDTH-1:0]    BUS,
  output logic [4*DIGITS-1:0]     o_VALUE,
  output logic [CURSOR_WIDTH-1:0] o_CURSOR,
  output logic                    o_VALID
);

  localparam int VW = 4 * DIGITS;
  localparam logic [CURSOR_WIDTH-1:0] CURSOR_LAST = CURSOR_WIDTH'(DIGITS - 1);

  logic digit_ev, inc_ev, commit_ev;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_digit (
    .clk(i_SYS_CLOCK), .rst(i_RESET), .clear_n(i_CLEAR_n), .btn_n(i_BTN_DIGIT), .press(digit_ev)
  );
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_inc (
    .clk(i_SYS_CLOCK), .rst(i_RESET), .clear_n(i_CLEAR_n), .btn_n(i_BTN_INC), .press(inc_ev)
  );
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_commit (
    .clk(i_SYS_CLOCK), .rst(i_RESET), .clear_n(i_CLEAR_n), .btn_n(i_BTN_COMMIT), .press(commit_ev)
  );

  state_t                  state_q, state_d;
  logic [VW-1:0]           working_q, working_d;
  logic [VW-1:0]           held_q, held_d;
  logic [CURSOR_WIDTH-1:0] cursor_q, cursor_d;
  logic                    valid_q, valid_d;

  // Clear outranks everything; in EDIT a single event is taken with COMMIT > INC > DIGIT,
  // and COMMIT also beats a coincident ACK because ACK is only looked at in PENDING.
  always_comb begin
    state_d   = state_q;
    working_d = working_q;
    held_d    = held_q;
    cursor_d  = cursor_q;
    valid_d   = valid_q;
    if (!i_CLEAR_n) begin
      state_d   = STATE_EDIT;
      working_d = '0;
      held_d    = '0;
      cursor_d  = '0;
      valid_d   = 1'b0;
    end else begin
      case (state_q)
        STATE_EDIT: begin
          if (commit_ev) begin
            held_d  = working_q;
            valid_d = 1'b1;
            state_d = STATE_PENDING;
          end else if (inc_ev) begin
            for (int i = 0; i < DIGITS; i++) begin
              if (cursor_q == CURSOR_WIDTH'(i)) begin
                working_d[4*i +: 4] = working_q[4*i +: 4] + 4'd1;
              end
            end
          end else if (digit_ev) begin
            cursor_d = (cursor_q == CURSOR_LAST) ? '0 : cursor_q + 1'b1;
          end
        end
        STATE_PENDING: begin
          if (i_ACK) begin
            valid_d = 1'b0;
            state_d = STATE_EDIT;
          end
        end
        default: state_d = STATE_EDIT;
      endcase
    end
  end

  always_ff @(posedge i_SYS_CLOCK or posedge i_RESET) begin
    if (i_RESET) begin
      state_q   <= STATE_EDIT;
      working_q <= '0;
      held_q    <= '0;
      cursor_q  <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      working_q <= working_d;
      held_q    <= held_d;
      cursor_q  <= cursor_d;
      valid_q   <= valid_d;
    end
  end

  assign o_VALUE  = working_q;
  assign o_CURSOR = cursor_q;
  assign o_VALID  = valid_q;

  // The held value is driven whenever enabled, even with nothing pending.
  assign BUS = i_OUTPUT_n ? {BUS_WIDTH{1'bz}} : BUS_WIDTH'(held_q);

endmodule

// File: tb/tb_input_register.sv
// Scoreboard bench for input_register with a short debounce window; expected register
// states are pushed when buttons are driven and popped once the DUT has settled.
module tb_input_register;

  localparam int DEB   = 4;
  localparam int HOLD  = DEB + 8;

  typedef struct {
    logic [23:0] value;
    logic [2:0]  cursor;
    logic        valid;
    logic [23:0] held;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear_n;
  logic        btn_digit, btn_inc, btn_commit;
  logic        output_n;
  logic        ack;
  wire  [31:0] bus;
  logic [23:0] value;
  logic [2:0]  cursor;
  logic        valid;

  int checks = 0;
  int errors = 0;

  exp_t        sb[$];
  exp_t        e;
  logic [23:0] m_value, m_held;
  logic [2:0]  m_cursor;
  logic        m_valid;

  // Released bus floats high so a missing release is visible.
  for (genvar g = 0; g < 32; g++) begin : g_pull
    pullup (bus[g]);
  end

  always #5 clk = ~clk;

  input_register #(.DEBOUNCE_CYCLES(DEB), .DIGITS(6), .BUS_WIDTH(32)) dut (
    .i_SYS_CLOCK(clk), .i_RESET(rst), .i_CLEAR_n(clear_n),
    .i_BTN_DIGIT(btn_digit), .i_BTN_INC(btn_inc), .i_BTN_COMMIT(btn_commit),
    .i_OUTPUT_n(output_n), .i_ACK(ack), .BUS(bus),
    .o_VALUE(value), .o_CURSOR(cursor), .o_VALID(valid)
  );

  task automatic model_reset();
    m_value  = '0;
    m_held   = '0;
    m_cursor = '0;
    m_valid  = 1'b0;
    sb.delete();
  endtask

  task automatic model_event(input bit inc, input bit dig, input bit com);
    if (!m_valid) begin
      if (com) begin
        m_held  = m_value;
        m_valid = 1'b1;
      end else if (inc) begin
        m_value[4*m_cursor +: 4] = m_value[4*m_cursor +: 4] + 4'd1;
      end else if (dig) begin
        m_cursor = (m_cursor == 3'd5) ? 3'd0 : m_cursor + 3'd1;
      end
    end
    sb.push_back('{m_value, m_cursor, m_valid, m_held});
  endtask

  task automatic press(input bit inc, input bit dig, input bit com);
    @(negedge clk);
    btn_inc    = ~inc;
    btn_digit  = ~dig;
    btn_commit = ~com;
    repeat (HOLD) @(negedge clk);
    btn_inc    = 1'b1;
    btn_digit  = 1'b1;
    btn_commit = 1'b1;
    repeat (HOLD) @(negedge clk);
    model_event(inc, dig, com);
  endtask

  task automatic do_ack();
    @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    @(negedge clk);
    if (m_valid) m_valid = 1'b0;
    sb.push_back('{m_value, m_cursor, m_valid, m_held});
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear_n = 1'b0;
    @(negedge clk);
    clear_n = 1'b1;
    @(negedge clk);
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1; clear_n = 1'b1; btn_digit = 1'b1; btn_inc = 1'b1; btn_commit = 1'b1;
    output_n = 1'b1; ack = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    checks++; if (value !== 24'h0) begin errors++; $display("[TB] FAIL reset_value got %h want 000000", value); end
    checks++; if (cursor !== 3'd0) begin errors++; $display("[TB] FAIL reset_cursor got %0d want 0", cursor); end
    checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b want 0", valid); end
    checks++; if (bus !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL reset_bus_released got %h want ffffffff", bus); end
    output_n = 1'b0;
    @(negedge clk);
    checks++; if (bus !== 32'h0) begin errors++; $display("[TB] FAIL reset_bus_driven got %h want 00000000", bus); end
    output_n = 1'b1;
  endtask

  task automatic test_edit();
    repeat (3) press(1, 0, 0);
    press(0, 1, 0);
    repeat (10) press(1, 0, 0);
    e = sb.pop_back(); sb.delete();
    checks++; if (value !== e.value || value !== 24'h0000A3) begin errors++; $display("[TB] FAIL edit_value got %h want %h", value, e.value); end
    checks++; if (cursor !== e.cursor || cursor !== 3'd1) begin errors++; $display("[TB] FAIL edit_cursor got %0d want %0d", cursor, e.cursor); end
    checks++; if (valid !== e.valid) begin errors++; $display("[TB] FAIL edit_valid got %b want %b", valid, e.valid); end
  endtask

  task automatic test_bounce();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); btn_inc = 1'b0;
      @(negedge clk);
      @(negedge clk); btn_inc = 1'b1;
    end
    @(negedge clk); btn_inc = 1'b0;
    repeat (HOLD) @(negedge clk);
    btn_inc = 1'b1;
    repeat (HOLD) @(negedge clk);
    model_event(1, 0, 0);
    e = sb.pop_front();
    checks++; if (value !== e.value || value !== 24'h0000B3) begin errors++; $display("[TB] FAIL bounce_single_inc got %h want %h", value, e.value); end
  endtask

  task automatic test_wrap();
    repeat (5) press(1, 0, 0);
    e = sb.pop_back(); sb.delete();
    checks++; if (value !== e.value || value !== 24'h000003) begin errors++; $display("[TB] FAIL digit_wrap got %h want %h", value, e.value); end
    repeat (5) press(0, 1, 0);
    e = sb.pop_back(); sb.delete();
    checks++; if (cursor !== e.cursor || cursor !== 3'd0) begin errors++; $display("[TB] FAIL cursor_to_zero got %0d want %0d", cursor, e.cursor); end
    repeat (5) press(0, 1, 0);
    e = sb.pop_back(); sb.delete();
    checks++; if (cursor !== e.cursor || cursor !== 3'd5) begin errors++; $display("[TB] FAIL cursor_five got %0d want %0d", cursor, e.cursor); end
    press(0, 1, 0);
    e = sb.pop_front();
    checks++; if (cursor !== e.cursor || cursor !== 3'd0) begin errors++; $display("[TB] FAIL cursor_wrap got %0d want %0d", cursor, e.cursor); end
  endtask

  task automatic test_commit();
    logic [23:0] target;
    int          budget;
    target = 24'h12AB34;
    do_clear();
    for (int d = 0; d < 6; d++) begin
      for (int n = 0; n < int'(target[4*d +: 4]); n++) press(1, 0, 0);
      press(0, 1, 0);
    end
    e = sb.pop_back(); sb.delete();
    checks++; if (value !== e.value || value !== 24'h12AB34) begin errors++; $display("[TB] FAIL build_value got %h want %h", value, e.value); end
    @(negedge clk); btn_commit = 1'b0;
    budget = 0;
    while (valid !== 1'b1 && budget < 50) begin @(negedge clk); budget++; end
    checks++; if (valid !== 1'b1) begin errors++; $display("[TB] FAIL commit_valid got %b want 1 (timeout)", valid); end
    btn_commit = 1'b1;
    repeat (HOLD) @(negedge clk);
    model_event(0, 0, 1);
    press(1, 0, 0);
    e = sb.pop_back(); sb.delete();
    checks++; if (value !== e.value || valid !== e.valid) begin errors++; $display("[TB] FAIL pending_inc_ignored got %h/%b want %h/%b", value, valid, e.value, e.valid); end
    output_n = 1'b0;
    @(negedge clk);
    checks++; if (bus !== {8'h00, e.held} || bus !== 32'h0012AB34) begin errors++; $display("[TB] FAIL bus_drive got %h want %h", bus, {8'h00, e.held}); end
    output_n = 1'b1;
    @(negedge clk);
    checks++; if (bus !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL bus_release got %h want ffffffff", bus); end
    do_ack();
    e = sb.pop_front();
    checks++; if (valid !== e.valid || valid !== 1'b0) begin errors++; $display("[TB] FAIL ack_valid got %b want %b", valid, e.valid); end
    checks++; if (value !== e.value || value !== 24'h12AB34) begin errors++; $display("[TB] FAIL ack_value_kept got %h want %h", value, e.value); end
    press(1, 0, 0);
    e = sb.pop_front();
    checks++; if (value !== e.value || value !== 24'h12AB35) begin errors++; $display("[TB] FAIL edit_after_ack got %h want %h", value, e.value); end
    do_ack();
    e = sb.pop_front();
    checks++; if (valid !== e.valid) begin errors++; $display("[TB] FAIL ack_in_edit got %b want %b", valid, e.valid); end
  endtask

  task automatic test_back_to_back();
    press(1, 0, 1);
    e = sb.pop_front();
    checks++; if (valid !== e.valid || valid !== 1'b1) begin errors++; $display("[TB] FAIL same_cycle_valid got %b want %b", valid, e.valid); end
    checks++; if (value !== e.value || value !== 24'h12AB35) begin errors++; $display("[TB] FAIL same_cycle_value got %h want %h", value, e.value); end
    output_n = 1'b0;
    @(negedge clk);
    checks++; if (bus !== {8'h00, e.held}) begin errors++; $display("[TB] FAIL same_cycle_held got %h want %h", bus, {8'h00, e.held}); end
    output_n = 1'b1;
    do_ack();
    sb.delete();
  endtask

  task automatic test_reset_clear();
    @(negedge clk); btn_inc = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    btn_inc = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (3 * HOLD) @(negedge clk);
    checks++; if (value !== m_value || cursor !== m_cursor || valid !== m_valid) begin errors++; $display("[TB] FAIL reset_mid_debounce got %h/%0d/%b want %h/%0d/%b", value, cursor, valid, m_value, m_cursor, m_valid); end
    press(1, 0, 0);
    press(0, 1, 0);
    press(0, 0, 1);
    e = sb.pop_back(); sb.delete();
    checks++; if (valid !== e.valid || value !== 24'h000001) begin errors++; $display("[TB] FAIL pre_clear got %h/%b want 000001/%b", value, valid, e.valid); end
    do_clear();
    repeat (3 * HOLD) @(negedge clk);
    output_n = 1'b0;
    @(negedge clk);
    checks++; if (value !== m_value || cursor !== m_cursor || valid !== m_valid) begin errors++; $display("[TB] FAIL clear_outputs got %h/%0d/%b want %h/%0d/%b", value, cursor, valid, m_value, m_cursor, m_valid); end
    checks++; if (bus !== {8'h00, m_held}) begin errors++; $display("[TB] FAIL clear_bus got %h want %h", bus, {8'h00, m_held}); end
    output_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_edit();
    test_bounce();
    test_wrap();
    test_commit();
    test_back_to_back();
    test_reset_clear();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
